// File: rtl/fdtd_ez_update_ctrl.sv
// Ez time-step sequencer for the 1-D FDTD engine: scans interior cells, issues the
// source load last, and aligns write-back strobes with the Ez calc pipeline.
module fdtd_ez_update_ctrl #(
   parameter int CELL_NUM   = 200,
   parameter int ADDR_WIDTH = 8,
   parameter int SRC_POS    = 100,
   parameter int PIPE_LAT   = 3,
   parameter int STEP_WIDTH = 16
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  start_i,
   input  logic                  ready_i,
   output logic                  calc_Ez_en_o,
   output logic                  calc_src_en_o,
   output logic [ADDR_WIDTH-1:0] rd_addr_o,
   output logic                  wr_en_o,
   output logic [ADDR_WIDTH-1:0] wr_addr_o,
   output logic                  busy_o,
   output logic                  step_done_o,
   output logic [STEP_WIDTH-1:0] n_step_o
);

   typedef enum logic [2:0] {IDLE, SCAN, SRC, DRAIN, DONE} state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(CELL_NUM - 2);
   localparam logic [ADDR_WIDTH-1:0] SRC_ADDR   = ADDR_WIDTH'(SRC_POS);
   localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(1);

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
   logic                    ez_en_q, ez_en_d;
   logic                    src_en_q, src_en_d;
   logic                    busy_q, busy_d;
   logic [STEP_WIDTH-1:0]   n_step_q, n_step_d;
   logic [PIPE_LAT-1:0]     dl_vld_q, dl_vld_d;
   logic [ADDR_WIDTH-1:0]   dl_addr_q [PIPE_LAT];
   logic [ADDR_WIDTH-1:0]   dl_addr_d [PIPE_LAT];
   logic                    line_empty;

   // Registered enables count as in flight until they have entered the delay line.
   assign line_empty = (dl_vld_q == '0) && !ez_en_q && !src_en_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rd_addr_q <= '0;
         ez_en_q   <= 1'b0;
         src_en_q  <= 1'b0;
         busy_q    <= 1'b0;
         n_step_q  <= '0;
         dl_vld_q  <= '0;
         for (int i = 0; i < PIPE_LAT; i++) dl_addr_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rd_addr_q <= rd_addr_d;
         ez_en_q   <= ez_en_d;
         src_en_q  <= src_en_d;
         busy_q    <= busy_d;
         n_step_q  <= n_step_d;
         dl_vld_q  <= dl_vld_d;
         for (int i = 0; i < PIPE_LAT; i++) dl_addr_q[i] <= dl_addr_d[i];
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i) state_d = SCAN;
         SCAN:    if (ready_i && (cnt_q == LAST_ADDR)) state_d = SRC;
         SRC:     if (ready_i) state_d = DRAIN;
         DRAIN:   if (line_empty) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ez_en_d   = 1'b0;
      src_en_d  = 1'b0;
      rd_addr_d = rd_addr_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      n_step_d  = n_step_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               cnt_d  = FIRST_ADDR;
               busy_d = 1'b1;
            end
         end
         SCAN: begin
            if (ready_i) begin
               ez_en_d   = 1'b1;
               rd_addr_d = cnt_q;
               cnt_d     = cnt_q + 1'b1;
            end
         end
         SRC: begin
            if (ready_i) begin
               src_en_d  = 1'b1;
               rd_addr_d = SRC_ADDR;
            end
         end
         DRAIN:   if (line_empty) n_step_d = n_step_q + 1'b1;
         DONE:    busy_d = 1'b0;
         default: ;
      endcase
   end

   // Write-back delay line shifts unconditionally; downstream never stalls.
   always_comb begin
      dl_vld_d[0]  = ez_en_q | src_en_q;
      dl_addr_d[0] = rd_addr_q;
      for (int i = 1; i < PIPE_LAT; i++) begin
         dl_vld_d[i]  = dl_vld_q[i-1];
         dl_addr_d[i] = dl_addr_q[i-1];
      end
   end

   assign calc_Ez_en_o  = ez_en_q;
   assign calc_src_en_o = src_en_q;
   assign rd_addr_o     = rd_addr_q;
   assign wr_en_o       = dl_vld_q[PIPE_LAT-1];
   assign wr_addr_o     = dl_addr_q[PIPE_LAT-1];
   assign busy_o        = busy_q;
   assign step_done_o   = (state_q == DONE);
   assign n_step_o      = n_step_q;

endmodule

// File: tb/tb_fdtd_ez_update_ctrl.sv
// Bench for fdtd_ez_update_ctrl: vector table for one full step plus a
// schedule-based reference model checked every cycle under random ready_i.
module tb_fdtd_ez_update_ctrl;

   localparam int N   = 8;
   localparam int SRC = 4;
   localparam int P   = 3;
   localparam int AW  = 8;
   localparam int SW  = 2;

   logic          CLK, RST, start_i, ready_i;
   logic          calc_Ez_en_o, calc_src_en_o, wr_en_o, busy_o, step_done_o;
   logic [AW-1:0] rd_addr_o, wr_addr_o;
   logic [SW-1:0] n_step_o;

   fdtd_ez_update_ctrl #(
      .CELL_NUM(N), .ADDR_WIDTH(AW), .SRC_POS(SRC), .PIPE_LAT(P), .STEP_WIDTH(SW)
   ) dut (
      .CLK(CLK), .RST(RST), .start_i(start_i), .ready_i(ready_i),
      .calc_Ez_en_o(calc_Ez_en_o), .calc_src_en_o(calc_src_en_o),
      .rd_addr_o(rd_addr_o), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
      .busy_o(busy_o), .step_done_o(step_done_o), .n_step_o(n_step_o)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int vecs = 0;
   int errs = 0;

   // Reference model: issue list position, scheduled write-backs, step-done deadline.
   int            cyc = 0;
   int            m_phase = 0;
   int            m_idx = 0;
   int            done_due = -1;
   int            due_q[$];
   logic [AW-1:0] addr_q[$];
   logic          e_ez, e_src, e_wr, e_busy, e_done;
   logic [AW-1:0] e_rd, e_wa;
   logic [SW-1:0] e_n;

   logic [AW-1:0] wlog[$];
   int            wr_cnt = 0;
   int            done_cnt = 0;

   task automatic model_edge(input logic r, input logic s, input logic y);
      cyc++;
      e_ez = 1'b0; e_src = 1'b0; e_wr = 1'b0; e_done = 1'b0;
      if (r) begin
         m_phase = 0; m_idx = 0; done_due = -1;
         e_busy = 1'b0; e_rd = '0; e_wa = '0; e_n = '0;
         due_q.delete(); addr_q.delete();
         return;
      end
      if (due_q.size() > 0 && due_q[0] == cyc) begin
         e_wr = 1'b1;
         e_wa = addr_q[0];
         void'(due_q.pop_front());
         void'(addr_q.pop_front());
      end
      case (m_phase)
         0: if (s) begin m_phase = 1; m_idx = 0; e_busy = 1'b1; end
         1: if (y) begin
               if (m_idx < N - 2) begin
                  e_ez = 1'b1; e_rd = AW'(m_idx + 1);
               end else begin
                  e_src = 1'b1; e_rd = AW'(SRC);
                  done_due = cyc + P + 2;
                  m_phase = 2;
               end
               due_q.push_back(cyc + P);
               addr_q.push_back(e_rd);
               m_idx++;
            end
         2: if (cyc == done_due) begin e_done = 1'b1; e_n = e_n + 1'b1; m_phase = 3; end
         default: begin e_busy = 1'b0; m_phase = 0; end
      endcase
   endtask

   task automatic check(input string name, input int act, input int exp);
      vecs++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic compare_model();
      logic ok;
      ok = (calc_Ez_en_o === e_ez) && (calc_src_en_o === e_src) && (rd_addr_o === e_rd) &&
           (wr_en_o === e_wr) && (!e_wr || wr_addr_o === e_wa) && (busy_o === e_busy) &&
           (step_done_o === e_done) && (n_step_o === e_n);
      vecs++;
      if (!ok) begin
         errs++;
         $display("FAIL model cyc %0d: got ez=%b src=%b rd=%0d wr=%b wa=%0d busy=%b done=%b n=%0d expected ez=%b src=%b rd=%0d wr=%b wa=%0d busy=%b done=%b n=%0d",
                  cyc, calc_Ez_en_o, calc_src_en_o, rd_addr_o, wr_en_o, wr_addr_o, busy_o, step_done_o, n_step_o,
                  e_ez, e_src, e_rd, e_wr, e_wa, e_busy, e_done, e_n);
      end
      if (calc_Ez_en_o && calc_src_en_o) begin
         vecs++; errs++;
         $display("FAIL enable_overlap cyc %0d: got ez=1 src=1 expected never both", cyc);
      end
      if (wr_en_o) begin wr_cnt++; wlog.push_back(wr_addr_o); end
      if (step_done_o) done_cnt++;
   endtask

   task automatic step(input logic r, input logic s, input logic y);
      RST = r; start_i = s; ready_i = y;
      @(posedge CLK);
      #1;
      model_edge(r, s, y);
      compare_model();
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
   endtask

   // Pulses start, then runs until step_done_o; mode 1 randomizes ready_i.
   // restart_at >= 0 re-pulses start while that address is being issued.
   task automatic run_step(input int mode, input int restart_at);
      int  budget;
      logic y, s;
      step(1'b0, 1'b1, 1'b1);
      budget = 0;
      while (!step_done_o && budget < 300) begin
         y = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
         s = (restart_at >= 0 && calc_Ez_en_o && rd_addr_o == AW'(restart_at));
         step(1'b0, s, y);
         budget++;
      end
      if (!step_done_o) begin
         vecs++; errs++;
         $display("FAIL step_timeout: got no step_done_o in %0d cycles expected one", budget);
      end
      step(1'b0, 1'b0, 1'b1);
   endtask

   typedef struct {
      logic rst, start, ready, ez, src;
      logic [AW-1:0] rd;
      logic wr;
      logic [AW-1:0] wa;
      logic busy, done;
      logic [SW-1:0] n;
   } tv_t;

   function automatic tv_t mk(input logic r, input logic s, input logic y, input logic ez, input logic sr,
                              input logic [AW-1:0] rd, input logic wr, input logic [AW-1:0] wa,
                              input logic b, input logic d, input logic [SW-1:0] n);
      tv_t t;
      t.rst = r; t.start = s; t.ready = y; t.ez = ez; t.src = sr; t.rd = rd;
      t.wr = wr; t.wa = wa; t.busy = b; t.done = d; t.n = n;
      return t;
   endfunction

   tv_t tv[15];
   logic [AW-1:0] exp_seq[7];

   initial begin
      RST = 1'b1; start_i = 1'b0; ready_i = 1'b1;
      e_ez = 0; e_src = 0; e_wr = 0; e_busy = 0; e_done = 0; e_rd = '0; e_wa = '0; e_n = '0;

      tv[0]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 2'd0);
      tv[1]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0, 2'd0);
      tv[2]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 1'b0, 8'd0, 1'b1, 1'b0, 2'd0);
      tv[3]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2, 1'b0, 8'd0, 1'b1, 1'b0, 2'd0);
      tv[4]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd3, 1'b0, 8'd0, 1'b1, 1'b0, 2'd0);
      tv[5]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd4, 1'b1, 8'd1, 1'b1, 1'b0, 2'd0);
      tv[6]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd5, 1'b1, 8'd2, 1'b1, 1'b0, 2'd0);
      tv[7]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd6, 1'b1, 8'd3, 1'b1, 1'b0, 2'd0);
      tv[8]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd4, 1'b1, 8'd4, 1'b1, 1'b0, 2'd0);
      tv[9]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4, 1'b1, 8'd5, 1'b1, 1'b0, 2'd0);
      tv[10] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4, 1'b1, 8'd6, 1'b1, 1'b0, 2'd0);
      tv[11] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4, 1'b1, 8'd4, 1'b1, 1'b0, 2'd0);
      tv[12] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4, 1'b0, 8'd0, 1'b1, 1'b0, 2'd0);
      tv[13] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4, 1'b0, 8'd0, 1'b1, 1'b1, 2'd1);
      tv[14] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4, 1'b0, 8'd0, 1'b0, 1'b0, 2'd1);
      exp_seq = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd4};

      // Full step with ready held high, cycle by cycle.
      for (int i = 0; i < 15; i++) begin
         step(tv[i].rst, tv[i].start, tv[i].ready);
         vecs++;
         if (calc_Ez_en_o !== tv[i].ez || calc_src_en_o !== tv[i].src || rd_addr_o !== tv[i].rd ||
             wr_en_o !== tv[i].wr || (tv[i].wr && wr_addr_o !== tv[i].wa) || busy_o !== tv[i].busy ||
             step_done_o !== tv[i].done || n_step_o !== tv[i].n) begin
            errs++;
            $display("FAIL table row %0d: got ez=%b src=%b rd=%0d wr=%b wa=%0d busy=%b done=%b n=%0d expected ez=%b src=%b rd=%0d wr=%b wa=%0d busy=%b done=%b n=%0d",
                     i, calc_Ez_en_o, calc_src_en_o, rd_addr_o, wr_en_o, wr_addr_o, busy_o, step_done_o, n_step_o,
                     tv[i].ez, tv[i].src, tv[i].rd, tv[i].wr, tv[i].wa, tv[i].busy, tv[i].done, tv[i].n);
         end
      end

      // Stall of two cycles after address 3 is issued.
      do_reset();
      wlog.delete(); wr_cnt = 0;
      step(1'b0, 1'b1, 1'b1);
      for (int b = 0; b < 20 && !(calc_Ez_en_o && rd_addr_o == 8'd3); b++) step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      check("stall_no_ez", int'(calc_Ez_en_o), 0);
      step(1'b0, 1'b0, 1'b0);
      check("stall_no_src", int'(calc_src_en_o), 0);
      step(1'b0, 1'b0, 1'b1);
      check("stall_resume_addr", int'(rd_addr_o), 4);
      for (int b = 0; b < 30 && !step_done_o; b++) step(1'b0, 1'b0, 1'b1);
      check("stall_wr_count", wr_cnt, 7);
      for (int k = 0; k < 7; k++)
         check($sformatf("stall_wr_seq%0d", k), (k < wlog.size()) ? int'(wlog[k]) : -1, int'(exp_seq[k]));

      // start_i during a running step is ignored.
      do_reset();
      done_cnt = 0;
      run_step(0, 5);
      for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b1);
      check("restart_done_count", done_cnt, 1);
      check("restart_n_step", int'(n_step_o), 1);
      run_step(0, -1);
      check("second_n_step", int'(n_step_o), 2);

      // Reset mid-scan discards pending writes.
      do_reset();
      step(1'b0, 1'b1, 1'b1);
      for (int b = 0; b < 20 && !(calc_Ez_en_o && rd_addr_o == 8'd3); b++) step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      check("rst_busy", int'(busy_o), 0);
      check("rst_rd_addr", int'(rd_addr_o), 0);
      check("rst_wr_en", int'(wr_en_o), 0);
      wr_cnt = 0;
      for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b1);
      check("rst_no_late_writes", wr_cnt, 0);
      check("rst_n_step", int'(n_step_o), 0);

      // Random ready_i over 50 steps.
      do_reset();
      for (int s = 0; s < 50; s++) begin
         wr_cnt = 0;
         run_step(1, -1);
         check($sformatf("rand_step%0d_writes", s), wr_cnt, 7);
      end

      // Step counter wraps at STEP_WIDTH=2.
      do_reset();
      for (int s = 0; s < 5; s++) begin
         run_step(0, -1);
         check($sformatf("wrap_n_step%0d", s), int'(n_step_o), (s + 1) % 4);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/fdtd_ez_update_ctrl.md
Name: fdtd_ez_update_ctrl

Overview:
Sequencer that drives one Ez time-step update for the 1-D FDTD engine. It scans the interior Ez cells and issues one calc_Ez_en_o pulse per cell, then issues a single calc_src_en_o pulse for the source cell. These two enables feed the Ez data selector. The block also produces the write-back address and write enable, delayed to line up with the Ez calc pipeline output, and counts completed time steps.

Parameters:
CELL_NUM, 200, number of Ez cells; cells 0 and CELL_NUM-1 are PEC boundaries and are never updated.
ADDR_WIDTH, 8, cell address width; CELL_NUM <= 2**ADDR_WIDTH.
SRC_POS, 100, source cell index; 1 <= SRC_POS <= CELL_NUM-2.
PIPE_LAT, 3, cycles from an enable at the selector input to valid Ez_n at write-back; PIPE_LAT >= 1.
STEP_WIDTH, 16, time-step counter width.

Ports:
CLK  input  1  clock; all logic on rising edge.
RST  input  1  synchronous reset, active-high.
start_i  input  1  one-cycle request to run one time step; honoured only in IDLE.
ready_i  input  1  downstream can accept an issue this cycle; issue stalls while low.
calc_Ez_en_o  output  1  total-field Ez update enable for rd_addr_o.
calc_src_en_o  output  1  source-load enable for rd_addr_o.
rd_addr_o  output  ADDR_WIDTH  cell address for the current issue.
wr_en_o  output  1  write-back strobe, aligned with the selected Ez_n.
wr_addr_o  output  ADDR_WIDTH  write-back cell address.
busy_o  output  1  high from the start_i accept until step_done_o, inclusive.
step_done_o  output  1  one-cycle pulse when a time step has fully written back.
n_step_o  output  STEP_WIDTH  completed time steps; wraps modulo 2**STEP_WIDTH.

Behaviour:
- Reset, synchronous with RST=1: state=IDLE. All outputs are 0, including n_step_o, the address counter and the delay line. Reset mid-step aborts immediately; partially issued writes in the delay line are discarded.
- States: IDLE, SCAN, SRC, DRAIN, DONE.
- IDLE:
  - On start_i=1, go to SCAN with the address counter at 1.
  - busy_o rises on the cycle after the accept.
- SCAN:
  - When ready_i=1: assert calc_Ez_en_o=1 with rd_addr_o=counter, then increment the counter.
  - When ready_i=0: both enables are 0 and the counter holds.
  - After issuing address CELL_NUM-2, go to SRC.
- SRC:
  - When ready_i=1: assert calc_src_en_o=1 with rd_addr_o=SRC_POS for exactly one cycle, then go to DRAIN.
  - When ready_i=0: wait.
- DRAIN: wait until the write-back delay line is empty, then go to DONE.
- DONE:
  - step_done_o=1 for one cycle and n_step_o increments.
  - Go to IDLE; busy_o falls in the same cycle as the transition to IDLE.
- Enable outputs are registered. calc_Ez_en_o and calc_src_en_o are never both 1 in a cycle; this is a hard invariant because the selector outputs 0 for 2'b11.
- rd_addr_o holds its last value when no enable is active.
- Write-back delay line:
  - A PIPE_LAT-deep shift register of {valid, addr}, loaded with {enable_active, rd_addr_o}.
  - It shifts every cycle, independent of ready_i; the downstream pipeline is stall-free once an issue is accepted.
  - wr_en_o / wr_addr_o are the last stage, so they appear exactly PIPE_LAT cycles after the matching enable.
- The source write targets SRC_POS after that cell's normal update has already been written back. The source value therefore overwrites the total-field value; this is the required ordering.
- start_i while busy_o=1 is ignored: no queuing, no error.
- Step latency with ready_i held at 1: accept → first enable is 1 cycle; total start_i → step_done_o is (CELL_NUM-2) + 1 + PIPE_LAT + 2 cycles.
- Address arithmetic is unsigned ADDR_WIDTH. The counter never wraps inside a step.

Test Plan:
1. CELL_NUM=8, SRC_POS=4, PIPE_LAT=3, ready_i=1; pulse start_i → calc_Ez_en_o high for rd_addr 1..6 on consecutive cycles, then calc_src_en_o at addr 4. wr_en_o shows addrs 1..6 then 4, each 3 cycles after its enable. step_done_o pulses once and n_step_o=1.
2. Same configuration, ready_i low for 2 cycles after addr 3 is issued → no enables during the stall, addr 4 issues after ready_i returns. The write sequence is still 1..6,4 with no duplicate or skipped address.
3. start_i pulsed again at addr 5 of a running step → ignored. Exactly one step_done_o, n_step_o=1; a subsequent start_i in IDLE yields n_step_o=2.
4. RST=1 while in SCAN at addr 3 with writes pending → next cycle: all outputs 0 and state IDLE. No wr_en_o follows after reset is released; n_step_o=0.
5. Random ready_i over 50 steps → a checker asserts calc_Ez_en_o & calc_src_en_o is never 1, and wr_en_o count = 7 per step.
6. STEP_WIDTH=2, run 5 steps → n_step_o goes 1,2,3,0,1.
